cheat_entry_controller: RTL and testbench

- Sequences the cheat-code entry screen ahead of the game session.
- Debounces the console address bus and decodes the on-screen UI "hotspot" fetches into digit edits and cursor moves.
- Holds the packed cheat digit string; detects the start-game handshake and hands the bus over to game mode.
- Feeds the cheat ROM address path and the cheat code decoders; switches the cart/replacement datapath from UI mode to game mode.

---
 rtl/cheat_entry_controller.sv | 219 +++++++++++++++++++++
 tb/tb_cheat_entry_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheat_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : cheat_entry_controller
// Description : Sequences the cheat-code entry screen ahead of the game
//               session. Debounces the console address bus and decodes the
//               UI hotspot fetches into digit edits and cursor moves. It holds
//               the packed cheat digit string and detects the start-game
//               handshake (START fetch followed by the reset-vector fetch).
//               On that handshake it hands the bus over to game mode, where
//               the address is passed through with a single register stage.
//
// Ports       : CLOCK_50      in   system clock (rising edge)
//               RESET_N       in   asynchronous active-low reset
//               CONSOLE_ADDR  in   raw console address bus (asynchronous)
//               STABLE_ADDR   out  accepted address (cheat ROM / data mux)
//               ADDR_STROBE   out  1-cycle pulse when STABLE_ADDR changes
//               SHOW_CHEAT_UI out  1 = entry screen, 0 = game mode
//               CHEAT_DIGITS  out  packed digit codes, digit i at [8i+7:8i]
//               CURSOR        out  index of the digit being edited
//               CHEATS_VALID  out  1-cycle pulse on entry to game mode
//
// Revision    : 1.0 - initial release
// ============================================================================
module cheat_entry_controller #(
    parameter int          NUM_DIGITS      = 15,
    parameter int          DEBOUNCE_CYCLES = 2,          // legal range 1..7
    parameter logic [12:0] INC_ADDR        = 13'h1150,
    parameter logic [12:0] DEC_ADDR        = 13'h1162,
    parameter logic [12:0] LEFT_ADDR       = 13'h1177,
    parameter logic [12:0] RIGHT_ADDR      = 13'h1190,
    parameter logic [12:0] START_ADDR      = 13'h104C,
    parameter logic [12:0] VECTOR_ADDR     = 13'h1FFC
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic [12:0]                   CONSOLE_ADDR,
    output logic [12:0]                   STABLE_ADDR,
    output logic                          ADDR_STROBE,
    output logic                          SHOW_CHEAT_UI,
    output logic [8*NUM_DIGITS-1:0]       CHEAT_DIGITS,
    output logic [$clog2(NUM_DIGITS)-1:0] CURSOR,
    output logic                          CHEATS_VALID
);

    localparam int               CUR_W      = $clog2(NUM_DIGITS);
    localparam int               CNT_W      = 3;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CUR_W-1:0] CUR_LAST   = CUR_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       DIGIT_DASH = 8'h02;   // first valid code
    localparam logic [7:0]       DIGIT_LAST = 8'h22;   // 'F', last valid code
    localparam logic [7:0]       DIGIT_STEP = 8'h02;

    typedef enum logic [1:0] {
        UI_IDLE  = 2'd0,
        UI_ARMED = 2'd1,
        GAME     = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [12:0]        shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [12:0]        stable_q, stable_d;
    logic               strobe_q, strobe_d;
    logic               valid_q,  valid_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [7:0]         digit_q [NUM_DIGITS];
    logic [7:0]         digit_d [NUM_DIGITS];

    // Hotspot edits only act on a freshly accepted address while the entry
    // screen is up; in game mode every bus change strobes and must be ignored.
    logic ui_strobe;
    assign ui_strobe = strobe_q && (state_q != GAME);

    // ------------------------------------------------------------------------
    // Address acceptance. In the UI states the shadow register is the sampler:
    // a new value reloads it and clears the run counter, an unchanged value
    // advances the counter. The acceptance decision is taken from the
    // registered counter, so once the run length has been reached the value
    // is committed even if the bus moves on in that same cycle.
    // ------------------------------------------------------------------------
    always_comb begin : p_debounce
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        strobe_d = 1'b0;

        if (state_q == GAME) begin
            stable_d = CONSOLE_ADDR;
            strobe_d = (CONSOLE_ADDR != stable_q);
        end else begin
            if (CONSOLE_ADDR != shadow_q) begin
                shadow_d = CONSOLE_ADDR;
                cnt_d    = '0;
            end else if (cnt_q != CNT_TARGET) begin
                cnt_d = cnt_q + 1'b1;
            end

            // Comparing against the current stable value gives exactly one
            // strobe per held address, however long it stays on the bus.
            if ((cnt_q == CNT_TARGET) && (shadow_q != stable_q)) begin
                stable_d = shadow_q;
                strobe_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Start handshake: START arms, the reset-vector fetch straight after it
    // enters game mode, anything else disarms.
    // ------------------------------------------------------------------------
    always_comb begin : p_fsm
        state_d = state_q;
        valid_d = 1'b0;

        if (strobe_q) begin
            case (state_q)
                UI_IDLE: begin
                    if (stable_q == START_ADDR) begin
                        state_d = UI_ARMED;
                    end
                end
                UI_ARMED: begin
                    if (stable_q == VECTOR_ADDR) begin
                        state_d = GAME;
                        valid_d = 1'b1;
                    end else if (stable_q == START_ADDR) begin
                        state_d = UI_ARMED;
                    end else begin
                        state_d = UI_IDLE;
                    end
                end
                GAME: begin
                    state_d = GAME;
                end
                default: begin
                    state_d = UI_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Hotspot decode: cursor moves wrap around the digit string, digit edits
    // wrap within dash..F. Codes outside the valid set just step by 2.
    // ------------------------------------------------------------------------
    always_comb begin : p_edit
        cursor_d = cursor_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = digit_q[i];
        end

        if (ui_strobe) begin
            if (stable_q == LEFT_ADDR) begin
                cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - 1'b1;
            end else if (stable_q == RIGHT_ADDR) begin
                cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
            end else if (stable_q == INC_ADDR) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cursor_q == CUR_W'(i)) begin
                        digit_d[i] = (digit_q[i] == DIGIT_LAST) ? DIGIT_DASH
                                                                : digit_q[i] + DIGIT_STEP;
                    end
                end
            end else if (stable_q == DEC_ADDR) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cursor_q == CUR_W'(i)) begin
                        digit_d[i] = (digit_q[i] == DIGIT_DASH) ? DIGIT_LAST
                                                                : digit_q[i] - DIGIT_STEP;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= UI_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            strobe_q <= 1'b0;
            valid_q  <= 1'b0;
            cursor_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_DASH;
            end
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            strobe_q <= strobe_d;
            valid_q  <= valid_d;
            cursor_q <= cursor_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign STABLE_ADDR   = stable_q;
    assign ADDR_STROBE   = strobe_q;
    assign SHOW_CHEAT_UI = (state_q != GAME);
    assign CURSOR        = cursor_q;
    assign CHEATS_VALID  = valid_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
        assign CHEAT_DIGITS[8*g +: 8] = digit_q[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_cheat_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cheat_entry_controller
// Description : Self-checking bench for cheat_entry_controller. A reference
//               model tracks the accepted address, cursor, digit values and
//               handshake progress in plain arithmetic terms; stimulus mixes
//               directed scenarios with random hotspot/noise sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cheat_entry_controller;

    localparam int          N      = 15;
    localparam int          D      = 2;
    localparam logic [12:0] A_INC  = 13'h1150;
    localparam logic [12:0] A_DEC  = 13'h1162;
    localparam logic [12:0] A_LEFT = 13'h1177;
    localparam logic [12:0] A_RGT  = 13'h1190;
    localparam logic [12:0] A_STRT = 13'h104C;
    localparam logic [12:0] A_VEC  = 13'h1FFC;

    logic           CLOCK_50     = 1'b0;
    logic           RESET_N      = 1'b0;
    logic [12:0]    CONSOLE_ADDR = 13'h0;
    logic [12:0]    STABLE_ADDR;
    logic           ADDR_STROBE;
    logic           SHOW_CHEAT_UI;
    logic [8*N-1:0] CHEAT_DIGITS;
    logic [3:0]     CURSOR;
    logic           CHEATS_VALID;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [7:0]  mdig [N];
    int          mcur;
    logic [12:0] mstable;
    bit          marmed;
    bit          mgame;
    logic [12:0] last_drive = 13'h0;

    always #5 CLOCK_50 = ~CLOCK_50;

    cheat_entry_controller #(
        .NUM_DIGITS      (N),
        .DEBOUNCE_CYCLES (D),
        .INC_ADDR        (A_INC),
        .DEC_ADDR        (A_DEC),
        .LEFT_ADDR       (A_LEFT),
        .RIGHT_ADDR      (A_RGT),
        .START_ADDR      (A_STRT),
        .VECTOR_ADDR     (A_VEC)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET_N       (RESET_N),
        .CONSOLE_ADDR  (CONSOLE_ADDR),
        .STABLE_ADDR   (STABLE_ADDR),
        .ADDR_STROBE   (ADDR_STROBE),
        .SHOW_CHEAT_UI (SHOW_CHEAT_UI),
        .CHEAT_DIGITS  (CHEAT_DIGITS),
        .CURSOR        (CURSOR),
        .CHEATS_VALID  (CHEATS_VALID)
    );

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mdig[i] = 8'h02;
        mcur    = 0;
        mstable = 13'h0;
        marmed  = 1'b0;
        mgame   = 1'b0;
    endfunction

    // digit as symbol index 0..16 (dash,0..F), stepped cyclically
    function automatic logic [7:0] step_digit(input logic [7:0] d, input int dir);
        int idx;
        idx = (int'(d) - 2) / 2;
        idx = (idx + dir + 17) % 17;
        return 8'(2 + 2 * idx);
    endfunction

    function automatic void model_accept(input logic [12:0] a, output int es, output int ev);
        es = 0;
        ev = 0;
        if (a == mstable) return;
        es      = 1;
        mstable = a;
        if (mgame) return;
        if (marmed && a == A_VEC) begin
            mgame = 1'b1;
            ev    = 1;
            return;
        end
        marmed = (a == A_STRT);
        if (a == A_INC)       mdig[mcur] = step_digit(mdig[mcur], 1);
        else if (a == A_DEC)  mdig[mcur] = step_digit(mdig[mcur], -1);
        else if (a == A_LEFT) mcur = (mcur + N - 1) % N;
        else if (a == A_RGT)  mcur = (mcur + 1) % N;
    endfunction

    function automatic logic [8*N-1:0] model_packed();
        logic [8*N-1:0] p;
        for (int i = 0; i < N; i++) p[8*i +: 8] = mdig[i];
        return p;
    endfunction

    task automatic hold(input logic [12:0] a, input int n, output int ns, output int nv);
        CONSOLE_ADDR = a;
        last_drive   = a;
        ns = 0;
        nv = 0;
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
            if (ADDR_STROBE === 1'b1)  ns++;
            if (CHEATS_VALID === 1'b1) nv++;
        end
    endtask

    task automatic accept(input logic [12:0] a, output int ns, output int nv,
                          output int es, output int ev);
        hold(a, D + 6, ns, nv);
        model_accept(a, es, ev);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int ns, nv;
        RESET_N      = 1'b0;
        CONSOLE_ADDR = 13'h1ABC;
        repeat (3) @(posedge CLOCK_50);
        #1;
        model_reset();
        n_tests++; if (STABLE_ADDR !== 13'h0) begin n_fail++; $display("FAIL reset_stable: got %h expected 0000", STABLE_ADDR); end
        n_tests++; if (ADDR_STROBE !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", ADDR_STROBE); end
        n_tests++; if (SHOW_CHEAT_UI !== 1'b1) begin n_fail++; $display("FAIL reset_show: got %b expected 1", SHOW_CHEAT_UI); end
        n_tests++; if (CURSOR !== 4'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d expected 0", CURSOR); end
        n_tests++; if (CHEATS_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", CHEATS_VALID); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL reset_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        CONSOLE_ADDR = 13'h0;
        last_drive   = 13'h0;
        RESET_N      = 1'b1;
        hold(13'h0, 6, ns, nv);
        n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL reset_release_strobe: got %0d strobes expected 0", ns); end
    endtask

    task automatic test_latency();
        int first, ns, es, ev;
        first = 0;
        ns    = 0;
        CONSOLE_ADDR = A_INC;
        last_drive   = A_INC;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLOCK_50);
            #1;
            if (ADDR_STROBE === 1'b1) begin
                ns++;
                if (first == 0) first = k;
            end
        end
        model_accept(A_INC, es, ev);
        n_tests++; if (first !== D + 2) begin n_fail++; $display("FAIL latency: got %0d clocks expected %0d", first, D + 2); end
        n_tests++; if (ns !== es) begin n_fail++; $display("FAIL latency_count: got %0d strobes expected %0d", ns, es); end
        n_tests++; if (CHEAT_DIGITS[7:0] !== 8'h04) begin n_fail++; $display("FAIL latency_digit0: got %h expected 04", CHEAT_DIGITS[7:0]); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL latency_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        n_tests++; if (STABLE_ADDR !== mstable) begin n_fail++; $display("FAIL latency_stable: got %h expected %h", STABLE_ADDR, mstable); end
    endtask

    task automatic test_glitch();
        int ns;
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            CONSOLE_ADDR = (i % 2 == 1) ? 13'h1151 : 13'h1150;
            @(posedge CLOCK_50);
            #1;
            if (ADDR_STROBE === 1'b1) ns++;
        end
        last_drive = CONSOLE_ADDR;
        n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL glitch_strobe: got %0d strobes expected 0", ns); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL glitch_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        n_tests++; if (STABLE_ADDR !== mstable) begin n_fail++; $display("FAIL glitch_stable: got %h expected %h", STABLE_ADDR, mstable); end
    endtask

    task automatic test_cursor();
        int ns, nv, es, ev;
        logic [12:0] seq [3];
        accept(A_LEFT, ns, nv, es, ev);
        n_tests++; if (ns !== es) begin n_fail++; $display("FAIL cursor_left_strobe: got %0d expected %0d", ns, es); end
        n_tests++; if (CURSOR !== 4'd14) begin n_fail++; $display("FAIL cursor_left_wrap: got %0d expected 14", CURSOR); end
        seq = '{A_RGT, 13'h0000, A_RGT};
        for (int i = 0; i < 3; i++) begin
            accept(seq[i], ns, nv, es, ev);
            n_tests++; if (ns !== es) begin n_fail++; $display("FAIL cursor_seq_strobe: addr %h got %0d expected %0d", seq[i], ns, es); end
        end
        n_tests++; if (CURSOR !== 4'd1) begin n_fail++; $display("FAIL cursor_right_wrap: got %0d expected 1", CURSOR); end
        n_tests++; if (CURSOR !== 4'(mcur)) begin n_fail++; $display("FAIL cursor_model: got %0d expected %0d", CURSOR, mcur); end
    endtask

    task automatic test_digit_wrap();
        int ns, nv, es, ev;
        logic [12:0] seq [4];
        seq = '{13'h0000, A_RGT, 13'h0000, A_RGT};
        for (int i = 0; i < 4; i++) accept(seq[i], ns, nv, es, ev);
        n_tests++; if (CURSOR !== 4'd3) begin n_fail++; $display("FAIL wrap_cursor: got %0d expected 3", CURSOR); end
        accept(A_DEC, ns, nv, es, ev);
        n_tests++; if (CHEAT_DIGITS[31:24] !== 8'h22) begin n_fail++; $display("FAIL wrap_dec: got %h expected 22", CHEAT_DIGITS[31:24]); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL wrap_dec_all: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        accept(A_INC, ns, nv, es, ev);
        n_tests++; if (CHEAT_DIGITS[31:24] !== 8'h02) begin n_fail++; $display("FAIL wrap_inc: got %h expected 02", CHEAT_DIGITS[31:24]); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL wrap_inc_all: got %h expected %h", CHEAT_DIGITS, model_packed()); end
    endtask

    task automatic test_armed_abort();
        int ns, nv, es, ev, nv_tot;
        logic [12:0] seq [3];
        seq = '{A_STRT, A_INC, A_VEC};
        nv_tot = 0;
        for (int i = 0; i < 3; i++) begin
            accept(seq[i], ns, nv, es, ev);
            nv_tot += nv;
            n_tests++; if (ns !== es) begin n_fail++; $display("FAIL abort_strobe: addr %h got %0d expected %0d", seq[i], ns, es); end
        end
        n_tests++; if (nv_tot !== 0) begin n_fail++; $display("FAIL abort_valid: got %0d pulses expected 0", nv_tot); end
        n_tests++; if (SHOW_CHEAT_UI !== 1'b1) begin n_fail++; $display("FAIL abort_show: got %b expected 1", SHOW_CHEAT_UI); end
        n_tests++; if (CHEAT_DIGITS[31:24] !== 8'h04) begin n_fail++; $display("FAIL abort_digit3: got %h expected 04", CHEAT_DIGITS[31:24]); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL abort_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
    endtask

    task automatic test_random();
        int ns, nv, es, ev;
        logic [12:0] a;
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0:       a = A_INC;
                1:       a = A_DEC;
                2:       a = A_LEFT;
                3:       a = A_RGT;
                4:       a = A_STRT;
                5:       a = A_INC;
                default: a = 13'($urandom);
            endcase
            if (a == last_drive) a = a ^ 13'h0001;
            if (a == A_VEC)      a = 13'h0000;
            if (a == last_drive) a = 13'h0001;
            if ($urandom_range(0, 2) == 0) begin
                hold(a, $urandom_range(1, D), ns, nv);
                n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL rand_short_strobe: addr %h got %0d expected 0", a, ns); end
            end else begin
                hold(a, $urandom_range(D + 3, D + 8), ns, nv);
                model_accept(a, es, ev);
                n_tests++; if (ns !== es) begin n_fail++; $display("FAIL rand_strobe: addr %h got %0d expected %0d", a, ns, es); end
                n_tests++; if (STABLE_ADDR !== mstable) begin n_fail++; $display("FAIL rand_stable: got %h expected %h", STABLE_ADDR, mstable); end
                n_tests++; if (CURSOR !== 4'(mcur)) begin n_fail++; $display("FAIL rand_cursor: got %0d expected %0d", CURSOR, mcur); end
                n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL rand_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
            end
            n_tests++; if (SHOW_CHEAT_UI !== 1'b1) begin n_fail++; $display("FAIL rand_show: got %b expected 1", SHOW_CHEAT_UI); end
        end
    endtask

    task automatic test_game();
        int ns, nv, es, ev;
        logic [12:0] prev, r;
        accept(13'h0000, ns, nv, es, ev);
        accept(A_STRT, ns, nv, es, ev);
        accept(A_VEC, ns, nv, es, ev);
        n_tests++; if (nv !== ev) begin n_fail++; $display("FAIL game_valid: got %0d pulses expected %0d", nv, ev); end
        n_tests++; if (SHOW_CHEAT_UI !== 1'b0) begin n_fail++; $display("FAIL game_show: got %b expected 0", SHOW_CHEAT_UI); end
        n_tests++; if (ns !== es) begin n_fail++; $display("FAIL game_entry_strobe: got %0d expected %0d", ns, es); end
        accept(A_INC, ns, nv, es, ev);
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL game_frozen_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        n_tests++; if (CURSOR !== 4'(mcur)) begin n_fail++; $display("FAIL game_frozen_cursor: got %0d expected %0d", CURSOR, mcur); end
        n_tests++; if (ns !== es) begin n_fail++; $display("FAIL game_change_strobe: got %0d expected %0d", ns, es); end
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL game_valid_once: got %0d pulses expected 0", nv); end
        for (int i = 0; i < 40; i++) begin
            prev = CONSOLE_ADDR;
            case ($urandom_range(0, 4))
                0:       r = prev;
                1:       r = A_LEFT;
                2:       r = A_DEC;
                default: r = 13'($urandom);
            endcase
            CONSOLE_ADDR = r;
            @(posedge CLOCK_50);
            #1;
            n_tests++; if (STABLE_ADDR !== r) begin n_fail++; $display("FAIL game_follow: got %h expected %h", STABLE_ADDR, r); end
            n_tests++; if (ADDR_STROBE !== (r != prev)) begin n_fail++; $display("FAIL game_follow_strobe: got %b expected %b", ADDR_STROBE, (r != prev)); end
        end
        mstable    = CONSOLE_ADDR;
        last_drive = CONSOLE_ADDR;
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL game_follow_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        n_tests++; if (CURSOR !== 4'(mcur)) begin n_fail++; $display("FAIL game_follow_cursor: got %0d expected %0d", CURSOR, mcur); end
    endtask

    task automatic test_reset_in_game();
        int ns, nv, es, ev;
        @(posedge CLOCK_50);
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        n_tests++; if (SHOW_CHEAT_UI !== 1'b1) begin n_fail++; $display("FAIL rst_game_show: got %b expected 1", SHOW_CHEAT_UI); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL rst_game_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        n_tests++; if (CURSOR !== 4'd0) begin n_fail++; $display("FAIL rst_game_cursor: got %0d expected 0", CURSOR); end
        n_tests++; if (STABLE_ADDR !== 13'h0) begin n_fail++; $display("FAIL rst_game_stable: got %h expected 0000", STABLE_ADDR); end
        n_tests++; if (ADDR_STROBE !== 1'b0 || CHEATS_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_game_pulses: got %b%b expected 00", ADDR_STROBE, CHEATS_VALID); end
        CONSOLE_ADDR = 13'h0;
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        hold(13'h0, 8, ns, nv);
        n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL rst_game_release: got %0d strobes expected 0", ns); end
        // reset in the middle of debouncing a hotspot
        CONSOLE_ADDR = A_DEC;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #2;
        RESET_N = 1'b0;
        #1;
        CONSOLE_ADDR = 13'h0;
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        hold(13'h0, 8, ns, nv);
        n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL rst_mid_debounce: got %0d strobes expected 0", ns); end
        n_tests++; if (CHEAT_DIGITS !== model_packed()) begin n_fail++; $display("FAIL rst_mid_digits: got %h expected %h", CHEAT_DIGITS, model_packed()); end
        accept(A_INC, ns, nv, es, ev);
        n_tests++; if (ns !== es) begin n_fail++; $display("FAIL rst_reaccept_strobe: got %0d expected %0d", ns, es); end
        n_tests++; if (CHEAT_DIGITS[7:0] !== 8'h04) begin n_fail++; $display("FAIL rst_reaccept_digit0: got %h expected 04", CHEAT_DIGITS[7:0]); end
        n_tests++; if (SHOW_CHEAT_UI !== 1'b1) begin n_fail++; $display("FAIL rst_reaccept_show: got %b expected 1", SHOW_CHEAT_UI); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_cursor();
        test_digit_wrap();
        test_armed_abort();
        test_random();
        test_game();
        test_reset_in_game();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
